// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, FSM state type and address-field helpers
// for the direct-mapped write-back L1 data cache.
package dcache_pkg;
  localparam int ADDR_W    = 32;
  localparam int LINE_W    = 256;
  localparam int NUM_LINES = 16;
  localparam int OFFSET_W  = 5;
  localparam int INDEX_W   = $clog2(NUM_LINES);
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS      = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } state_t;

  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INDEX_W-1:0] idx_t;
  typedef logic [2:0]         word_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [LINE_W-1:0]  line_t;

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1:INDEX_W+OFFSET_W];
  endfunction

  function automatic idx_t addr_idx(input addr_t a);
    return a[INDEX_W+OFFSET_W-1:OFFSET_W];
  endfunction

  function automatic word_t addr_word(input addr_t a);
    return a[OFFSET_W-1:2];
  endfunction

  function automatic addr_t line_addr(input tag_t t, input idx_t i);
    return {t, i, {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: MEM-stage request port plus line-wide memory port
// of the data cache, bundled for the controller and its environment.
interface dcache_if;
  import dcache_pkg::*;

  logic        cpu_req_i;
  logic        cpu_we_i;
  addr_t       cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        cpu_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  addr_t       mem_addr_o;
  line_t       mem_data_o;
  line_t       mem_data_i;
  logic        mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    input  mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    output mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_sram.sv
// dcache_sram: per-line valid/dirty/tag and data storage;
// async read, sync word store or full-line fill.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  idx_t        idx,
  output logic        rd_valid,
  output logic        rd_dirty,
  output tag_t        rd_tag,
  output line_t       rd_line,
  input  logic        wr_word,
  input  word_t       wr_sel,
  input  logic [31:0] wr_data,
  input  logic        fill,
  input  tag_t        fill_tag,
  input  line_t       fill_line,
  input  logic        clr_dirty
);
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  tag_t                 tags [NUM_LINES];
  line_t                data [NUM_LINES];

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_line  = data[idx];

  // Line status: cleared on reset, set by fills and store hits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (clr_dirty) begin
      dirty[idx] <= 1'b0;
    end else if (wr_word) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data arrays keep their contents across reset.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tags[idx] <= fill_tag;
      data[idx] <= fill_line;
    end else if (wr_word) begin
      data[idx][{wr_sel, 5'd0} +: 32] <= wr_data;
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate L1
// D-cache; hit logic, miss FSM and registered memory port.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  dcache_if.slave  bus
);
  state_t state, nxt;
  tag_t   miss_tag;
  idx_t   miss_idx;
  idx_t   idx;
  logic   v_valid, v_dirty;
  tag_t   v_tag;
  line_t  v_line;
  logic   hit, ld_hit, st_hit, fill, clr;
  logic   mem_req, mem_we;
  addr_t  mem_addr;
  line_t  mem_data;

  assign idx    = (state == IDLE) ? addr_idx(bus.cpu_addr_i)
                                  : miss_idx;
  assign hit    = (state == IDLE) & v_valid
                & (v_tag == addr_tag(bus.cpu_addr_i));
  assign ld_hit = bus.cpu_req_i & hit & ~bus.cpu_we_i;
  assign st_hit = bus.cpu_req_i & hit & bus.cpu_we_i;
  assign fill   = (state == REFILL) & bus.mem_ack_i;
  assign clr    = (state == WRITEBACK) & bus.mem_ack_i;

  assign bus.cpu_stall_o = bus.cpu_req_i & ~hit;
  assign bus.cpu_data_o  = ld_hit
    ? v_line[{addr_word(bus.cpu_addr_i), 5'd0} +: 32] : '0;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_data_o  = mem_data;

  dcache_sram u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx       (idx),
    .rd_valid  (v_valid),
    .rd_dirty  (v_dirty),
    .rd_tag    (v_tag),
    .rd_line   (v_line),
    .wr_word   (st_hit),
    .wr_sel    (addr_word(bus.cpu_addr_i)),
    .wr_data   (bus.cpu_data_i),
    .fill      (fill),
    .fill_tag  (miss_tag),
    .fill_line (bus.mem_data_i),
    .clr_dirty (clr)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state: miss -> optional write-back -> refill -> idle.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (bus.cpu_req_i && !hit) nxt = MISS;
      MISS:      nxt = (v_valid && v_dirty) ? WRITEBACK : REFILL;
      WRITEBACK: if (bus.mem_ack_i) nxt = REFILL;
      REFILL:    if (bus.mem_ack_i) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Miss latch and memory-port registers; request stays level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_tag <= '0;
      miss_idx <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cpu_req_i && !hit) begin
            miss_tag <= addr_tag(bus.cpu_addr_i);
            miss_idx <= addr_idx(bus.cpu_addr_i);
          end
        end
        MISS: begin
          mem_req <= 1'b1;
          if (v_valid && v_dirty) begin
            mem_we   <= 1'b1;
            mem_addr <= line_addr(v_tag, miss_idx);
            mem_data <= v_line;
          end else begin
            mem_we   <= 1'b0;
            mem_addr <= line_addr(miss_tag, miss_idx);
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack_i) begin
            mem_we   <= 1'b0;
            mem_addr <= line_addr(miss_tag, miss_idx);
          end
        end
        REFILL: begin
          if (bus.mem_ack_i) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed accesses with a scoreboard for
// CPU completions and memory requests, plus a 10-cycle memory model.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcache_if bus();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] data;
    int          stall;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    int          w;
    logic [31:0] word;
  } mem_exp_t;

  cpu_exp_t cq[$];
  mem_exp_t mq[$];
  int checks = 0;
  int errors = 0;

  logic [255:0] mem_lines [logic [31:0]];

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem_lines.exists(a)) return mem_lines[a];
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = (a + 32'(w * 4)) ^ 32'hA5A5_0000;
    return l;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void mexp(input logic we, input logic [31:0] a,
                               input int w, input logic [31:0] word);
    mq.push_back('{we, a, w, word});
  endfunction

  // Memory model: ack 10 cycles after a request is accepted.
  logic         busy = 1'b0;
  int           cnt;
  logic         mwe;
  logic [31:0]  maddr;
  logic [255:0] mdata;
  mem_exp_t     me;

  always @(negedge clk) begin
    bus.mem_ack_i = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else begin
      if (!busy && bus.mem_req_o) begin
        busy  = 1'b1;
        cnt   = 0;
        mwe   = bus.mem_we_o;
        maddr = bus.mem_addr_o;
        mdata = bus.mem_data_o;
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_req: got addr %h we %b expected none",
                   maddr, mwe);
        end else begin
          me = mq.pop_front();
          chk("mem_we", {31'd0, mwe}, {31'd0, me.we});
          chk("mem_addr", maddr, me.addr);
          if (me.we)
            chk("wb_word", mdata[me.w*32 +: 32], me.word);
        end
      end
      if (busy) begin
        cnt++;
        if (cnt == 10) begin
          busy = 1'b0;
          bus.mem_ack_i = 1'b1;
          if (mwe) mem_lines[maddr] = mdata;
          else     bus.mem_data_i = mem_line(maddr);
        end
      end
    end
  end

  // CPU monitor: count stall cycles, check each completed access.
  int       scnt = 0;
  cpu_exp_t ce;

  always @(negedge clk) begin
    if (rst) begin
      scnt = 0;
    end else if (bus.cpu_req_i) begin
      if (bus.cpu_stall_o) begin
        scnt++;
      end else begin
        if (cq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got addr %h expected none",
                   bus.cpu_addr_i);
        end else begin
          ce = cq.pop_front();
          if (ce.we) chk("store_data_o", bus.cpu_data_o, 32'd0);
          else       chk("load_data", bus.cpu_data_o, ce.data);
          chk("stall_cycles", scnt, ce.stall);
        end
        scnt = 0;
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp,
                        input int st);
    cq.push_back('{we, exp, st});
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = a;
    bus.cpu_data_i = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.cpu_stall_o) break;
      if (i == 99) begin
        checks++;
        errors++;
        $display("FAIL timeout: got stall after 100 cycles at %h expected release", a);
      end
    end
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b0;
  endtask

  initial begin
    bus.cpu_req_i  = 1'b0;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    @(posedge clk);
    #1;

    mexp(1'b0, 32'h40, 0, 32'h0);
    access(1'b0, 32'h40, 32'h0, 32'hA5A5_0040, 12);
    access(1'b0, 32'h40, 32'h0, 32'hA5A5_0040, 0);
    access(1'b1, 32'h44, 32'hDEAD_BEEF, 32'h0, 0);
    access(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 0);

    mexp(1'b1, 32'h40, 1, 32'hDEAD_BEEF);
    mexp(1'b0, 32'h240, 0, 32'h0);
    access(1'b0, 32'h240, 32'h0, 32'hA5A5_0240, 22);

    mexp(1'b0, 32'h80, 0, 32'h0);
    access(1'b1, 32'h80, 32'h1234_5678, 32'h0, 12);
    access(1'b0, 32'h80, 32'h0, 32'h1234_5678, 0);
    mexp(1'b1, 32'h80, 0, 32'h1234_5678);
    mexp(1'b0, 32'h280, 0, 32'h0);
    access(1'b0, 32'h280, 32'h0, 32'hA5A5_0280, 22);

    mexp(1'b0, 32'h40, 0, 32'h0);
    access(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 12);

    access(1'b1, 32'h48, 32'hCAFE_F00D, 32'h0, 0);
    mexp(1'b1, 32'h40, 2, 32'hCAFE_F00D);
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h248;
    repeat (5) @(posedge clk);
    #1;
    chk("wb_in_flight", {31'd0, bus.mem_req_o}, 32'd1);
    rst = 1'b1;
    bus.cpu_req_i = 1'b0;
    #1;
    chk("rst_abort_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_abort_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    mexp(1'b0, 32'h40, 0, 32'h0);
    access(1'b0, 32'h40, 32'h0, 32'hA5A5_0040, 12);
    access(1'b0, 32'h48, 32'h0, 32'hA5A5_0048, 0);
    access(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 0);

    repeat (20) @(posedge clk);
    #1;
    chk("cpu_q_drained", 32'(cq.size()), 32'd0);
    chk("mem_q_drained", 32'(mq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
